// File: rtl/debug_trace_pkg.sv
// Shared definitions for the debug trace unit.
// Holds the configuration register offsets, the CTRL register field layout
// and the trace packet id encoding.
package debug_trace_pkg;

  // Register offsets relative to CFG_BASE. Per-trigger registers repeat every
  // REGS_PER_TRIG numbers, starting at REG_CTRL for trigger 0.
  localparam int REG_GLOBAL    = 0;
  localparam int REG_CTRL      = 1;
  localparam int REG_LO        = 2;
  localparam int REG_HI        = 3;
  localparam int REGS_PER_TRIG = 3;

  // DCP command marker
  localparam int CMD_BIT = 31;

  // GLOBAL register bits
  localparam int GLB_EN_BIT      = 0;
  localparam int GLB_CLR_OVF_BIT = 1;

  // CTRL register fields
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_RD_BIT   = 1;
  localparam int CTRL_WR_BIT   = 2;
  localparam int CTRL_INCL_BIT = 3;
  localparam int CTRL_CH_LSB   = 4;
  localparam int CTRL_CH_W     = 3;
  localparam int CTRL_THR_LSB  = 8;
  localparam int CTRL_THR_W    = 8;

  // Requester select value that routes events to the SPI side
  localparam logic [1:0] SEL_SPI = 2'b11;

  typedef struct packed {
    logic [CTRL_THR_W-1:0] thr;
    logic [CTRL_CH_W-1:0]  ch;
    logic                  incl;
    logic                  wr;
    logic                  rd;
    logic                  en;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] trig;
    logic [3:0] ch;
  } tp_id_t;

  function automatic tp_id_t make_tp_id(input logic [3:0] trig, input logic [3:0] ch);
    tp_id_t id;
    id.trig = trig;
    id.ch   = ch;
    return id;
  endfunction

endpackage

// File: rtl/debug_trace_fifo.sv
// Synchronous trace FIFO with registered head outputs.
// Ports:
//   clk, MRST        clock, asynchronous active-low reset (clears contents)
//   push, push_data  write request and data (ignored when full unless popping)
//   pop              read request (ignored when empty)
//   full, empty      occupancy flags
//   head_data        registered oldest entry, zero when empty
module debug_trace_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             MRST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = head_q;

  // A push into a full FIFO is accepted when the same cycle frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr_q + 1'b1;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_nxt;
    end

    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end

    // Head register tracks what mem[rd_ptr] will hold after this cycle, so a
    // push into an empty FIFO is visible on the very next cycle.
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_pop) begin
      head_d = (count_q == CW'(1)) ? push_data : mem_q[rd_nxt];
    end else if (count_q == '0) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk or negedge MRST) begin
    if (!MRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/debug_trace_unit.sv
// Memory-access trigger and trace unit for the DLX SoC debug path.
// Snoops NCH core data ports, evaluates NTRIG address-window triggers with
// hit-count thresholds and queues trace packets for the debug wrapper.
// Ports:
//   clk, MRST                 clock, asynchronous active-low reset
//   ch_addr/ch_din/ch_dout    per-channel address, read data, write data
//   ch_rd/ch_wr               per-channel read/write strobes
//   DCP, Sel                  debug command word and requester select
//   tp_data/tp_id/tp_valid    trace FIFO head, tp_ready pops it
//   EV                        one-cycle event code (trigger index + 1)
//   ovf                       sticky packet-drop flag
module debug_trace_unit
  import debug_trace_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NTRIG      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CFG_BASE   = 48
) (
  input  logic              clk,
  input  logic              MRST,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_din,
  input  logic [NCH*DW-1:0] ch_dout,
  input  logic [NCH-1:0]    ch_rd,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [31:0]       DCP,
  input  logic [1:0]        Sel,
  output logic [DW-1:0]     tp_data,
  output logic [7:0]        tp_id,
  output logic              tp_valid,
  input  logic              tp_ready,
  output logic [7:0]        EV,
  output logic              ovf
);

  localparam logic [7:0] RN_GLOBAL = 8'(CFG_BASE + REG_GLOBAL);

  // Command/data handshake on DCP
  logic       tag_q, tag_d;
  logic [7:0] regno_q, regno_d;
  logic [1:0] sel_q, sel_d;
  logic       cfg_wr;

  logic       glb_en_q, glb_en_d;
  logic       ovf_q, ovf_d;
  logic [7:0] ev_q, ev_d;
  logic       clr_ovf;

  logic [NTRIG-1:0]         req;
  logic [NTRIG-1:0][DW-1:0] s1_data_all;
  logic [NTRIG-1:0][2:0]    s1_ch_all;

  logic          found, drop;
  logic [3:0]    win_id;
  logic [DW-1:0] win_data;
  logic [2:0]    win_ch;

  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DW+7:0] fifo_din, fifo_head;

  // A command in the data cycle re-arms the tag instead of writing.
  assign cfg_wr = tag_q & ~DCP[CMD_BIT];

  always_comb begin
    tag_d   = DCP[CMD_BIT];
    regno_d = DCP[CMD_BIT] ? DCP[7:0] : regno_q;
    sel_d   = DCP[CMD_BIT] ? Sel : sel_q;
  end

  for (genvar t = 0; t < NTRIG; t++) begin : g_trig
    localparam logic [7:0] RN_CTRL = 8'(CFG_BASE + REG_CTRL + REGS_PER_TRIG*t);
    localparam logic [7:0] RN_LO   = 8'(CFG_BASE + REG_LO + REGS_PER_TRIG*t);
    localparam logic [7:0] RN_HI   = 8'(CFG_BASE + REG_HI + REGS_PER_TRIG*t);

    ctrl_t         ctrl_q, ctrl_d;
    logic [AW-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          s1_hit_q, s1_hit_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic [2:0]    s1_ch_q, s1_ch_d;
    logic          wr_ctrl, wr_lo, wr_hi;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_dout;
    logic          m_rd, m_wr, in_win, req_t;

    assign wr_ctrl = cfg_wr && (regno_q == RN_CTRL);
    assign wr_lo   = cfg_wr && (regno_q == RN_LO);
    assign wr_hi   = cfg_wr && (regno_q == RN_HI);

    always_comb begin
      ctrl_d = ctrl_q;
      lo_d   = lo_q;
      hi_d   = hi_q;
      if (wr_ctrl) begin
        ctrl_d.en   = DCP[CTRL_EN_BIT];
        ctrl_d.rd   = DCP[CTRL_RD_BIT];
        ctrl_d.wr   = DCP[CTRL_WR_BIT];
        ctrl_d.incl = DCP[CTRL_INCL_BIT];
        ctrl_d.ch   = DCP[CTRL_CH_LSB +: CTRL_CH_W];
        ctrl_d.thr  = DCP[CTRL_THR_LSB +: CTRL_THR_W];
      end
      if (wr_lo) lo_d = AW'(DCP);
      if (wr_hi) hi_d = AW'(DCP);
    end

    // Channel mux; a channel field >= NCH selects nothing and never matches.
    always_comb begin
      m_addr = '0;
      m_din  = '0;
      m_dout = '0;
      m_rd   = 1'b0;
      m_wr   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (ctrl_q.ch == 3'(i)) begin
          m_addr = ch_addr[i*AW +: AW];
          m_din  = ch_din[i*DW +: DW];
          m_dout = ch_dout[i*DW +: DW];
          m_rd   = ch_rd[i];
          m_wr   = ch_wr[i];
        end
      end
    end

    always_comb begin
      if (ctrl_q.incl) begin
        in_win = (m_addr >= lo_q) && (m_addr <= hi_q);
      end else begin
        in_win = (m_addr > lo_q) && (m_addr < hi_q);
      end
      s1_hit_d  = glb_en_q & ctrl_q.en & in_win &
                  ((m_rd & ctrl_q.rd) | (m_wr & ctrl_q.wr));
      // Read data wins when both strobes are active.
      s1_data_d = m_rd ? m_din : m_dout;
      s1_ch_d   = ctrl_q.ch;
    end

    // Threshold 0 and 1 both push on every hit.
    always_comb begin
      cnt_d = cnt_q;
      req_t = 1'b0;
      if (s1_hit_q) begin
        if (({1'b0, cnt_q} + 9'd1) >= {1'b0, ctrl_q.thr}) begin
          req_t = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      if (wr_ctrl) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge MRST) begin
      if (!MRST) begin
        ctrl_q    <= '0;
        lo_q      <= '0;
        hi_q      <= '0;
        cnt_q     <= '0;
        s1_hit_q  <= 1'b0;
        s1_data_q <= '0;
        s1_ch_q   <= '0;
      end else begin
        ctrl_q    <= ctrl_d;
        lo_q      <= lo_d;
        hi_q      <= hi_d;
        cnt_q     <= cnt_d;
        s1_hit_q  <= s1_hit_d;
        s1_data_q <= s1_data_d;
        s1_ch_q   <= s1_ch_d;
      end
    end

    assign req[t]         = req_t;
    assign s1_data_all[t] = s1_data_q;
    assign s1_ch_all[t]   = s1_ch_q;
  end

  // Lowest-index request wins; any other request this cycle is lost.
  always_comb begin
    found    = 1'b0;
    drop     = 1'b0;
    win_id   = '0;
    win_data = '0;
    win_ch   = '0;
    for (int t = 0; t < NTRIG; t++) begin
      if (req[t]) begin
        if (!found) begin
          found    = 1'b1;
          win_id   = 4'(t);
          win_data = s1_data_all[t];
          win_ch   = s1_ch_all[t];
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  assign fifo_pop  = tp_valid & tp_ready;
  assign fifo_push = found & (~fifo_full | fifo_pop);
  assign fifo_din  = {make_tp_id(win_id, {1'b0, win_ch}), win_data};

  always_comb begin
    clr_ovf  = cfg_wr && (regno_q == RN_GLOBAL) && DCP[GLB_CLR_OVF_BIT];
    glb_en_d = glb_en_q;
    if (cfg_wr && (regno_q == RN_GLOBAL)) glb_en_d = DCP[GLB_EN_BIT];

    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop || (found && fifo_full && !fifo_pop)) ovf_d = 1'b1;

    ev_d = '0;
    if (fifo_push && (sel_q == SEL_SPI)) ev_d = 8'(win_id) + 8'd1;
  end

  always_ff @(posedge clk or negedge MRST) begin
    if (!MRST) begin
      tag_q    <= 1'b0;
      regno_q  <= '0;
      sel_q    <= '0;
      glb_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      ev_q     <= '0;
    end else begin
      tag_q    <= tag_d;
      regno_q  <= regno_d;
      sel_q    <= sel_d;
      glb_en_q <= glb_en_d;
      ovf_q    <= ovf_d;
      ev_q     <= ev_d;
    end
  end

  debug_trace_fifo #(
    .WIDTH (DW + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .MRST      (MRST),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  assign tp_valid = ~fifo_empty;
  assign tp_id    = fifo_head[DW +: 8];
  assign tp_data  = fifo_head[DW-1:0];
  assign EV       = ev_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_debug_trace_unit.sv
module tb_debug_trace_unit;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              MRST;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH*DW-1:0] ch_din = '0;
  logic [NCH*DW-1:0] ch_dout = '0;
  logic [NCH-1:0]    ch_rd = '0;
  logic [NCH-1:0]    ch_wr = '0;
  logic [31:0]       DCP = '0;
  logic [1:0]        Sel = '0;
  logic [DW-1:0]     tp_data;
  logic [7:0]        tp_id;
  logic              tp_valid;
  logic              tp_ready = 1'b0;
  logic [7:0]        EV;
  logic              ovf;

  int checks = 0;
  int errors = 0;
  logic [DW+7:0] exp_q[$];

  debug_trace_unit dut (
    .clk      (clk),
    .MRST     (MRST),
    .ch_addr  (ch_addr),
    .ch_din   (ch_din),
    .ch_dout  (ch_dout),
    .ch_rd    (ch_rd),
    .ch_wr    (ch_wr),
    .DCP      (DCP),
    .Sel      (Sel),
    .tp_data  (tp_data),
    .tp_id    (tp_id),
    .tp_valid (tp_valid),
    .tp_ready (tp_ready),
    .EV       (EV),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [7:0] regno, input logic [31:0] data);
    DCP = 32'h8000_0000 | {24'h0, regno};
    step(1);
    DCP = data;
    step(1);
    DCP = '0;
  endtask

  task automatic set_ch(input int i, input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] din, input logic [31:0] dout);
    ch_addr[i*AW +: AW] = a;
    ch_din[i*DW +: DW]  = din;
    ch_dout[i*DW +: DW] = dout;
    ch_rd[i]            = rd;
    ch_wr[i]            = wr;
  endtask

  task automatic clr_ch();
    ch_addr = '0;
    ch_din  = '0;
    ch_dout = '0;
    ch_rd   = '0;
    ch_wr   = '0;
  endtask

  task automatic access(input int i, input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] din, input logic [31:0] dout);
    set_ch(i, a, rd, wr, din, dout);
    step(1);
    clr_ch();
  endtask

  // Waits (bounded) for a head entry, compares it with the scoreboard, pops it.
  task automatic pop_check(input string tag);
    logic [DW+7:0] e;
    int n;
    n = 0;
    while (tp_valid !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed packet expected empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(tp_valid), 64'd1);
      chk(tag, 64'({tp_id, tp_data}), 64'(e));
    end
    tp_ready = 1'b1;
    step(1);
    tp_ready = 1'b0;
  endtask

  initial begin
    MRST = 1'b0;
    step(3);
    chk("rst_valid", 64'(tp_valid), 64'd0);
    chk("rst_data", 64'(tp_data), 64'd0);
    chk("rst_id", 64'(tp_id), 64'd0);
    chk("rst_ev", 64'(EV), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    MRST = 1'b1;
    step(2);

    // 1: trig0 strict window 0x100..0x200, reads on ch0, threshold 0
    wr_reg(8'd50, 32'h100);
    wr_reg(8'd51, 32'h200);
    wr_reg(8'd49, 32'h0003);
    wr_reg(8'd48, 32'h1);
    exp_q.push_back({8'h00, 32'hCAFE_0001});
    access(0, 32'h150, 1'b1, 1'b0, 32'hCAFE_0001, 32'h0);
    chk("lat_c1", 64'(tp_valid), 64'd0);
    step(1);
    chk("lat_c2", 64'(tp_valid), 64'd1);
    pop_check("t1_pkt");
    access(0, 32'h100, 1'b1, 1'b0, 32'h1111_1111, 32'h0);
    step(3);
    chk("strict_lo", 64'(tp_valid), 64'd0);
    access(0, 32'h200, 1'b1, 1'b0, 32'h2222_2222, 32'h0);
    step(3);
    chk("strict_hi", 64'(tp_valid), 64'd0);
    exp_q.push_back({8'h00, 32'h3333_3333});
    access(0, 32'h1FF, 1'b1, 1'b0, 32'h3333_3333, 32'h0);
    pop_check("edge_in");

    // 2: trig1 inclusive 0x40..0x40, writes on ch3, SPI requester
    Sel = 2'b11;
    wr_reg(8'd53, 32'h40);
    wr_reg(8'd54, 32'h40);
    wr_reg(8'd52, 32'h003D);
    exp_q.push_back({8'h13, 32'h1234_5678});
    access(3, 32'h40, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
    step(1);
    chk("ev_pulse", 64'(EV), 64'd2);
    step(1);
    chk("ev_clear", 64'(EV), 64'd0);
    pop_check("t2_pkt");

    // 3: threshold 3 with five reads
    wr_reg(8'd49, 32'h0303);
    exp_q.push_back({8'h00, 32'hD000_0003});
    for (int i = 1; i <= 5; i++) begin
      access(0, 32'h150, 1'b1, 1'b0, 32'hD000_0000 + 32'(i), 32'h0);
      step(1);
      chk($sformatf("thr_rd%0d", i), 64'(tp_valid), (i >= 3) ? 64'd1 : 64'd0);
    end
    pop_check("thr_pkt");
    step(2);
    chk("thr_once", 64'(tp_valid), 64'd0);
    exp_q.push_back({8'h00, 32'hD000_0006});
    access(0, 32'h150, 1'b1, 1'b0, 32'hD000_0006, 32'h0);
    pop_check("thr_cnt2");

    // 4: overflow with the consumer stalled
    wr_reg(8'd49, 32'h0003);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back({8'h00, 32'hA000_0000 + 32'(i)});
      access(0, 32'h150, 1'b1, 1'b0, 32'hA000_0000 + 32'(i), 32'h0);
    end
    step(2);
    chk("full_ovf", 64'(ovf), 64'd1);
    for (int i = 0; i < 8; i++) begin
      pop_check($sformatf("fifo_%0d", i));
    end
    chk("fifo_drained", 64'(tp_valid), 64'd0);
    wr_reg(8'd48, 32'h3);
    chk("ovf_clr", 64'(ovf), 64'd0);
    exp_q.push_back({8'h00, 32'hBEEF_0001});
    access(0, 32'h150, 1'b1, 1'b0, 32'hBEEF_0001, 32'h0);
    pop_check("en_kept");

    // 5: both triggers hit in one cycle
    set_ch(0, 32'h150, 1'b1, 1'b0, 32'h5555_0000, 32'h0);
    set_ch(3, 32'h40, 1'b0, 1'b1, 32'h0, 32'h6666_0000);
    exp_q.push_back({8'h00, 32'h5555_0000});
    step(1);
    clr_ch();
    step(1);
    chk("arb_ev", 64'(EV), 64'd1);
    chk("arb_ovf", 64'(ovf), 64'd1);
    pop_check("arb_pkt");
    step(2);
    chk("arb_single", 64'(tp_valid), 64'd0);

    // 6: reset with entries queued
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'h00, 32'hC000_0000 + 32'(i)});
      access(0, 32'h150, 1'b1, 1'b0, 32'hC000_0000 + 32'(i), 32'h0);
    end
    step(2);
    chk("pre_rst_valid", 64'(tp_valid), 64'd1);
    MRST = 1'b0;
    #1;
    chk("mrst_valid", 64'(tp_valid), 64'd0);
    chk("mrst_data", 64'(tp_data), 64'd0);
    chk("mrst_ovf", 64'(ovf), 64'd0);
    exp_q.delete();
    #2;
    MRST = 1'b1;
    step(1);
    access(0, 32'h150, 1'b1, 1'b0, 32'h7777_7777, 32'h0);
    step(3);
    chk("no_reprog", 64'(tp_valid), 64'd0);
    chk("no_reprog_ev", 64'(EV), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
